// File: rtl/ahbmtx_pkg.sv
// ahbmtx_pkg: shared AHB encodings and bundles
// for the bus-matrix stages.
package ahbmtx_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_INCR = 3'b001;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] auser;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } addr_ph_t;

endpackage

// File: rtl/ahbmtx_in_stg.sv
// ahbmtx_in_stg: master-side input stage, holds
// an address phase while the output stage is busy.
module ahbmtx_in_stg
  import ahbmtx_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [31:0] HAUSERS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic        active_ip,
  input  logic        readyout_ip,
  input  logic [1:0]  resp_ip,
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [31:0] auser_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic        held_tran_ip,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS
);

  addr_ph_t live;
  addr_ph_t held;
  addr_ph_t req;

  logic pend_tran;
  logic burst_ovr;
  logic data_phase;

  logic new_tran;
  logic accept;
  logic load;
  logic held_seq;
  logic ovr_clr;
  logic use_ovr;

  assign live = '{
    addr:     HADDRS,
    auser:    HAUSERS,
    trans:    HTRANSS,
    write:    HWRITES,
    size:     HSIZES,
    burst:    HBURSTS,
    prot:     HPROTS,
    master:   HMASTERS,
    mastlock: HMASTLOCKS
  };

  assign new_tran = HSELS & HREADYS & HTRANSS[1];
  assign accept   = active_ip & readyout_ip;
  // a stray HREADYS while holding must not clobber the held phase
  assign load     = HSELS & HREADYS & ~pend_tran;
  assign held_seq = pend_tran & (held.trans == TRANS_SEQ);
  // NONSEQ/IDLE sampled from this port ends the rewritten burst
  assign ovr_clr  = HSELS & HREADYS & ~HTRANSS[0];
  assign use_ovr  = held_seq | (burst_ovr & ~ovr_clr);

  // capture the address phase whenever the master samples one
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held <= '0;
    end else if (load) begin
      held <= live;
    end
  end

  // a transfer not taken this cycle waits here until accepted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_tran <= 1'b0;
    end else if (pend_tran) begin
      if (accept) pend_tran <= 1'b0;
    end else if (new_tran & ~accept) begin
      pend_tran <= 1'b1;
    end
  end

  // a held SEQ restarts as NONSEQ, so the rest becomes INCR
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      burst_ovr <= 1'b0;
    end else if (held_seq) begin
      burst_ovr <= 1'b1;
    end else if (ovr_clr) begin
      burst_ovr <= 1'b0;
    end
  end

  // track an accepted transfer through its data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_phase <= 1'b0;
    end else if (readyout_ip | ~data_phase) begin
      data_phase <= held_tran_ip & accept;
    end
  end

  assign req = pend_tran ? held : live;

  assign sel_ip       = pend_tran | HSELS;
  assign addr_ip      = req.addr;
  assign auser_ip     = req.auser;
  assign write_ip     = req.write;
  assign size_ip      = req.size;
  assign prot_ip      = req.prot;
  assign master_ip    = req.master;
  assign mastlock_ip  = req.mastlock;
  assign held_tran_ip = pend_tran | new_tran;

  assign trans_ip = held_seq ? TRANS_NONSEQ : req.trans;
  assign burst_ip = use_ovr ? BURST_INCR : req.burst;

  // stall while holding, else mirror the serving slave
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    if (pend_tran) begin
      HREADYOUTS = 1'b0;
    end else if (data_phase) begin
      HREADYOUTS = readyout_ip;
      HRESPS     = resp_ip;
    end
  end

endmodule

// File: tb/tb_ahbmtx_in_stg.sv
// tb_ahbmtx_in_stg: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_ahbmtx_in_stg;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [31:0] HAUSERS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_ip;
  logic        readyout_ip;
  logic [1:0]  resp_ip;
  logic        sel_ip;
  logic [31:0] addr_ip;
  logic [31:0] auser_ip;
  logic [1:0]  trans_ip;
  logic        write_ip;
  logic [2:0]  size_ip;
  logic [2:0]  burst_ip;
  logic [3:0]  prot_ip;
  logic [3:0]  master_ip;
  logic        mastlock_ip;
  logic        held_tran_ip;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  int n_vec = 0;
  int n_err = 0;

  assign HREADYS = HREADYOUTS;

  always #5 HCLK = ~HCLK;

  ahbmtx_in_stg dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS),
    .HAUSERS(HAUSERS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES),
    .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .active_ip(active_ip),
    .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .sel_ip(sel_ip), .addr_ip(addr_ip),
    .auser_ip(auser_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip),
    .burst_ip(burst_ip), .prot_ip(prot_ip),
    .master_ip(master_ip), .mastlock_ip(mastlock_ip),
    .held_tran_ip(held_tran_ip),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] auser;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        lock;
  } xfer_t;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HSELS = 0; HADDRS = 0; HAUSERS = 0;
    HTRANSS = 2'b00; HWRITES = 0; HSIZES = 0;
    HBURSTS = 0; HPROTS = 0; HMASTERS = 0;
    HMASTLOCKS = 0; active_ip = 0;
    readyout_ip = 1; resp_ip = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 0;
    #1;
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", HREADYOUTS); end
    n_vec++; if (HRESPS !== 2'b00) begin n_err++; $display("FAIL rst_resp got %b want 00", HRESPS); end
    n_vec++; if (held_tran_ip !== 1'b0) begin n_err++; $display("FAIL rst_held got %b want 0", held_tran_ip); end
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1;
    @(negedge HCLK);
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got %b want 1", HREADYOUTS); end
  endtask

  task automatic test_nonseq_write();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; HWRITES = 1;
    HADDRS = 32'h2000_0000; active_ip = 1; readyout_ip = 1;
    @(negedge HCLK);
    n_vec++; if (held_tran_ip !== 1'b1) begin n_err++; $display("FAIL wr_held got %b want 1", held_tran_ip); end
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL wr_ready got %b want 1", HREADYOUTS); end
    n_vec++; if (addr_ip !== 32'h2000_0000) begin n_err++; $display("FAIL wr_addr got %h want 20000000", addr_ip); end
    n_vec++; if (write_ip !== 1'b1) begin n_err++; $display("FAIL wr_write got %b want 1", write_ip); end
    tick();
    HTRANSS = 2'b00; readyout_ip = 0;
    @(negedge HCLK);
    n_vec++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL wr_wait got %b want 0", HREADYOUTS); end
    tick();
    readyout_ip = 1;
    @(negedge HCLK);
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL wr_done got %b want 1", HREADYOUTS); end
    tick();
    readyout_ip = 0;
    @(negedge HCLK);
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL wr_after got %b want 1", HREADYOUTS); end
    tick();
  endtask

  task automatic test_held_read();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; HWRITES = 0;
    HADDRS = 32'h4000_0010; active_ip = 0; readyout_ip = 1;
    @(negedge HCLK);
    n_vec++; if (HREADYOUTS !== 1'b1) begin n_err++; $display("FAIL rd_issue_ready got %b want 1", HREADYOUTS); end
    tick();
    HTRANSS = 2'b00; HADDRS = 32'hDEAD_BEEF; HWRITES = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_vec++; if (addr_ip !== 32'h4000_0010) begin n_err++; $display("FAIL rd_hold_addr got %h want 40000010", addr_ip); end
      n_vec++; if ({held_tran_ip, sel_ip, trans_ip, write_ip} !== 5'b11100) begin n_err++; $display("FAIL rd_hold_ctl got %b want 11100", {held_tran_ip, sel_ip, trans_ip, write_ip}); end
      n_vec++; if (HREADYOUTS !== 1'b0) begin n_err++; $display("FAIL rd_hold_ready got %b want 0", HREADYOUTS); end
      tick();
    end
    active_ip = 1;
    @(negedge HCLK);
    n_vec++; if ({held_tran_ip, HREADYOUTS} !== 2'b10) begin n_err++; $display("FAIL rd_accept got %b want 10", {held_tran_ip, HREADYOUTS}); end
    tick();
    @(negedge HCLK);
    n_vec++; if ({held_tran_ip, HREADYOUTS} !== 2'b01) begin n_err++; $display("FAIL rd_complete got %b want 01", {held_tran_ip, HREADYOUTS}); end
    tick();
  endtask

  task automatic test_burst_override();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; HBURSTS = 3'b011;
    HADDRS = 32'h1000_0000; active_ip = 1; readyout_ip = 1;
    @(negedge HCLK);
    n_vec++; if (burst_ip !== 3'b011) begin n_err++; $display("FAIL bu_b1 got %b want 011", burst_ip); end
    tick();
    HTRANSS = 2'b11; HADDRS = 32'h1000_0004; active_ip = 0;
    @(negedge HCLK);
    n_vec++; if ({trans_ip, burst_ip} !== 5'b11011) begin n_err++; $display("FAIL bu_b2_live got %b want 11011", {trans_ip, burst_ip}); end
    tick();
    for (int i = 0; i < 2; i++) begin
      active_ip = (i == 1);
      @(negedge HCLK);
      n_vec++; if ({trans_ip, burst_ip, HREADYOUTS} !== 6'b100010) begin n_err++; $display("FAIL bu_held got %b want 100010", {trans_ip, burst_ip, HREADYOUTS}); end
      n_vec++; if (addr_ip !== 32'h1000_0004) begin n_err++; $display("FAIL bu_held_addr got %h want 10000004", addr_ip); end
      tick();
    end
    active_ip = 1;
    for (int i = 0; i < 2; i++) begin
      HADDRS = 32'h1000_0008 + 32'(4 * i);
      @(negedge HCLK);
      n_vec++; if ({trans_ip, burst_ip, HREADYOUTS} !== 6'b110011) begin n_err++; $display("FAIL bu_tail got %b want 110011", {trans_ip, burst_ip, HREADYOUTS}); end
      tick();
    end
    HTRANSS = 2'b10; HBURSTS = 3'b000; HADDRS = 32'h3000_0000;
    tick();
    HBURSTS = 3'b010;
    @(negedge HCLK);
    n_vec++; if (burst_ip !== 3'b010) begin n_err++; $display("FAIL bu_new got %b want 010", burst_ip); end
    tick();
    HTRANSS = 2'b00;
    tick();
  endtask

  task automatic test_error();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; active_ip = 1; readyout_ip = 1;
    tick();
    HTRANSS = 2'b00; resp_ip = 2'b01; readyout_ip = 0;
    @(negedge HCLK);
    n_vec++; if ({HRESPS, HREADYOUTS} !== 3'b010) begin n_err++; $display("FAIL err_c1 got %b want 010", {HRESPS, HREADYOUTS}); end
    tick();
    readyout_ip = 1;
    @(negedge HCLK);
    n_vec++; if ({HRESPS, HREADYOUTS} !== 3'b011) begin n_err++; $display("FAIL err_c2 got %b want 011", {HRESPS, HREADYOUTS}); end
    tick();
    @(negedge HCLK);
    n_vec++; if (HRESPS !== 2'b00) begin n_err++; $display("FAIL err_after got %b want 00", HRESPS); end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; HMASTLOCKS = 1;
    active_ip = 0; readyout_ip = 1;
    @(negedge HCLK);
    n_vec++; if (mastlock_ip !== 1'b1) begin n_err++; $display("FAIL lk_issue got %b want 1", mastlock_ip); end
    tick();
    HMASTLOCKS = 0; HTRANSS = 2'b00; active_ip = 1;
    @(negedge HCLK);
    n_vec++; if ({mastlock_ip, held_tran_ip} !== 2'b11) begin n_err++; $display("FAIL lk_hold got %b want 11", {mastlock_ip, held_tran_ip}); end
    tick();
    HMASTLOCKS = 1; HTRANSS = 2'b11;
    @(negedge HCLK);
    n_vec++; if ({mastlock_ip, HREADYOUTS} !== 2'b11) begin n_err++; $display("FAIL lk_next got %b want 11", {mastlock_ip, HREADYOUTS}); end
    tick();
    HMASTLOCKS = 0; HTRANSS = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    HSELS = 1; HTRANSS = 2'b10; active_ip = 0; readyout_ip = 1;
    tick();
    HSELS = 0; HTRANSS = 2'b00;
    @(negedge HCLK);
    n_vec++; if (held_tran_ip !== 1'b1) begin n_err++; $display("FAIL rh_pending got %b want 1", held_tran_ip); end
    #1 HRESETn = 0;
    #1;
    n_vec++; if ({held_tran_ip, HREADYOUTS} !== 2'b01) begin n_err++; $display("FAIL rh_async got %b want 01", {held_tran_ip, HREADYOUTS}); end
    tick();
    HRESETn = 1; active_ip = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_vec++; if ({held_tran_ip, sel_ip, HREADYOUTS} !== 3'b001) begin n_err++; $display("FAIL rh_after got %b want 001", {held_tran_ip, sel_ip, HREADYOUTS}); end
      tick();
    end
  endtask

  task automatic test_random();
    xfer_t q[$];
    xfer_t w;
    xfer_t cur;
    bit owed;
    bit incr_mode;
    bit hr;
    bit acc;
    logic [86:0] got;
    logic [86:0] exp;
    logic [1:0]  e_trans;
    logic [2:0]  e_burst;
    do_reset();
    owed = 0;
    incr_mode = 0;
    for (int c = 0; c < 600; c++) begin
      HSELS = ($urandom_range(0, 3) != 0);
      HTRANSS = 2'($urandom);
      HADDRS = $urandom; HAUSERS = $urandom;
      HWRITES = 1'($urandom); HSIZES = 3'($urandom);
      HBURSTS = 3'($urandom); HPROTS = 4'($urandom);
      HMASTERS = 4'($urandom); HMASTLOCKS = 1'($urandom);
      active_ip = 1'($urandom);
      readyout_ip = ($urandom_range(0, 3) != 0);
      resp_ip = {1'b0, 1'($urandom)};
      cur = '{HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES,
              HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
      if (q.size() != 0) begin
        w = q[0];
        hr = 0;
        e_trans = (w.trans == 2'b11) ? 2'b10 : w.trans;
        e_burst = (w.trans == 2'b11) ? 3'b001 : w.burst;
        exp = {1'b1, w.addr, w.auser, e_trans, w.write, w.size,
               e_burst, w.prot, w.master, w.lock, 1'b1, 1'b0, 2'b00};
      end else begin
        hr = owed ? readyout_ip : 1'b1;
        e_burst = (incr_mode && !(HSELS && hr && !HTRANSS[0])) ? 3'b001 : HBURSTS;
        exp = {HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES,
               e_burst, HPROTS, HMASTERS, HMASTLOCKS,
               HSELS & hr & HTRANSS[1], hr, owed ? resp_ip : 2'b00};
      end
      @(negedge HCLK);
      got = {sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip,
             burst_ip, prot_ip, master_ip, mastlock_ip,
             held_tran_ip, HREADYOUTS, HRESPS};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rand_c%0d got %h want %h", c, got, exp);
      end
      acc = active_ip & readyout_ip;
      if (q.size() != 0) begin
        if (q[0].trans == 2'b11) incr_mode = 1;
        if (acc) begin
          void'(q.pop_front());
          owed = 1;
        end
      end else if (hr) begin
        if (HSELS && !HTRANSS[0]) incr_mode = 0;
        if (HSELS && HTRANSS[1]) begin
          if (acc) owed = 1;
          else begin
            q.push_back(cur);
            owed = 0;
          end
        end else begin
          owed = 0;
        end
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nonseq_write();
    test_held_read();
    test_burst_override();
    test_error();
    test_lock();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
